// File: rtl/board_io_pkg.sv
// ============================================================================
// Module : board_io_pkg
// Brief  : Register map and bus constants shared by the board I/O peripheral.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package board_io_pkg;

    localparam int BUS_DW = 32;

    // Byte offsets; the bus decodes addr[4:2] and ignores addr[1:0].
    localparam logic [4:0] REG_SW_STATE = 5'h00;
    localparam logic [4:0] REG_LED      = 5'h04;
    localparam logic [4:0] REG_PENDING  = 5'h08;
    localparam logic [4:0] REG_IRQ_EN   = 5'h0C;
    localparam logic [4:0] REG_PWM_DUTY = 5'h10;

    function automatic logic [4:0] word_offset(input logic [4:0] addr);
        return {addr[4:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// ============================================================================
// Module : io_debounce
// Brief  : One switch bit: two-flop synchroniser followed by a hold-time
//          debounce counter. 'changed' pulses on the cycle stable updates.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic changed
);

    localparam int             CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    assign w_accept = (r_sync != r_stable) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= pin;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable  = r_stable;
    assign changed = w_accept;

endmodule

`default_nettype wire

// File: rtl/board_io_ctrl.sv
// ============================================================================
// Module : board_io_ctrl
// Brief  : Board I/O peripheral: debounced switches, LED register, edge
//          pending bits with level irq. Optional LED PWM via BOARD_IO_PWM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int SW_WIDTH        = 4,
    parameter int LED_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PWM_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SW_WIDTH-1:0]  pin_switch,
    output logic [LED_WIDTH-1:0] pin_led,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [4:0]           req_addr,
    input  logic [BUS_DW-1:0]    req_wdata,
    output logic                 resp_valid,
    output logic [BUS_DW-1:0]    resp_rdata,
    output logic                 irq
);

    logic [SW_WIDTH-1:0]  w_stable;
    logic [SW_WIDTH-1:0]  w_changed;
    logic [LED_WIDTH-1:0] r_led;
    logic [SW_WIDTH-1:0]  r_pending;
    logic [SW_WIDTH-1:0]  r_irq_en;
    logic                 r_resp_valid;
    logic [BUS_DW-1:0]    r_resp_rdata;
    logic                 r_irq;

    logic                 w_accept;
    logic                 w_wr;
    logic [4:0]           w_off;
    logic [BUS_DW-1:0]    w_rdata;
    logic [SW_WIDTH-1:0]  w_w1c;
    logic                 w_unused;

    generate
        for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
            io_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset   (reset),
                .pin     (pin_switch[i]),
                .stable  (w_stable[i]),
                .changed (w_changed[i])
            );
        end
    endgenerate

    assign req_ready = !r_resp_valid;
    assign w_accept  = req_valid && !r_resp_valid;
    assign w_wr      = w_accept && req_we;
    assign w_off     = word_offset(req_addr);
    assign w_w1c     = (w_wr && (w_off == REG_PENDING)) ? req_wdata[SW_WIDTH-1:0] : '0;
    assign w_unused  = ^{req_addr[1:0], req_wdata};

`ifdef BOARD_IO_PWM_EN
    logic [PWM_WIDTH-1:0] r_pwm_cnt;
    logic [PWM_WIDTH-1:0] r_duty;
    logic [LED_WIDTH-1:0] r_pin_led;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_cnt <= '0;
            r_duty    <= '1;
            r_pin_led <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_wr && (w_off == REG_PWM_DUTY))
                r_duty <= req_wdata[PWM_WIDTH-1:0];
            r_pin_led <= r_led & {LED_WIDTH{r_pwm_cnt < r_duty}};
        end
    end

    assign pin_led = r_pin_led;
`else
    logic [PWM_WIDTH-1:0] w_unused_pwm;
    assign w_unused_pwm = '0;
    assign pin_led      = r_led;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_SW_STATE: w_rdata[SW_WIDTH-1:0]  = w_stable;
            REG_LED:      w_rdata[LED_WIDTH-1:0] = r_led;
            REG_PENDING:  w_rdata[SW_WIDTH-1:0]  = r_pending;
            REG_IRQ_EN:   w_rdata[SW_WIDTH-1:0]  = r_irq_en;
`ifdef BOARD_IO_PWM_EN
            REG_PWM_DUTY: w_rdata[PWM_WIDTH-1:0] = r_duty;
`endif
            default:      w_rdata = '0;
        endcase
    end

    // A new edge on a bit overrides a simultaneous write-one-to-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led        <= '0;
            r_pending    <= '0;
            r_irq_en     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_w1c) | w_changed;
            r_irq     <= |(r_pending & r_irq_en);
            if (w_wr && (w_off == REG_LED))
                r_led <= req_wdata[LED_WIDTH-1:0];
            if (w_wr && (w_off == REG_IRQ_EN))
                r_irq_en <= req_wdata[SW_WIDTH-1:0];
            r_resp_valid <= w_accept;
            r_resp_rdata <= (w_accept && !req_we) ? w_rdata : '0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
// ============================================================================
// Module : tb_board_io_ctrl
// Brief  : Directed self-checking bench for board_io_ctrl (DEBOUNCE_CYCLES=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_board_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pin_switch;
    logic [3:0]  pin_led;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .SW_WIDTH        (4),
        .LED_WIDTH       (4),
        .DEBOUNCE_CYCLES (4),
        .PWM_WIDTH       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pin_switch (pin_switch),
        .pin_led    (pin_led),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .irq        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One access: drive on a falling edge, accept on the next rising edge,
    // sample the response on the following falling edge.
    task automatic bus(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                       output logic [31:0] data);
        @(negedge clk);
        chk("bus_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bus_resp_valid", {31'd0, resp_valid}, 32'd1);
        data = resp_rdata;
        if (we) chk("bus_wr_rdata", resp_rdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        pin_switch = '0;

        // Reset with toggling pins
        repeat (4) begin
            @(negedge clk);
            pin_switch = ~pin_switch;
        end
        @(negedge clk);
        chk("rst_pin_led",    {28'd0, pin_led}, 32'd0);
        chk("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_irq",        {31'd0, irq}, 32'd0);
        pin_switch = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus(1'b0, 5'h00, 32'd0, rd);
        chk("rst_sw_state", rd, 32'd0);
        bus(1'b0, 5'h08, 32'd0, rd);
        chk("rst_pending", rd, 32'd0);

        // Enable irq on bit 0, then debounce a rising edge
        bus(1'b1, 5'h0C, 32'h1, rd);
        @(negedge clk);
        pin_switch = 4'b0001;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("deb_irq_not_yet", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("deb_irq_set", {31'd0, irq}, 32'd1);
        bus(1'b0, 5'h00, 32'd0, rd);
        chk("deb_sw_state", rd, 32'h1);
        bus(1'b0, 5'h08, 32'd0, rd);
        chk("deb_pending", rd, 32'h1);

        // 3-cycle glitch on bit 1 is rejected
        @(negedge clk);
        pin_switch = 4'b0011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        pin_switch = 4'b0001;
        repeat (10) @(posedge clk);
        bus(1'b0, 5'h00, 32'd0, rd);
        chk("glitch_sw_state", rd, 32'h1);
        bus(1'b0, 5'h08, 32'd0, rd);
        chk("glitch_pending", rd, 32'h1);

        // W1C clears pending and irq
        bus(1'b1, 5'h08, 32'h1, rd);
        bus(1'b0, 5'h08, 32'd0, rd);
        chk("w1c_pending", rd, 32'h0);
        chk("w1c_irq", {31'd0, irq}, 32'd0);

        // W1C accepted on the same edge the falling edge of bit 0 is accepted
        @(negedge clk);
        pin_switch = 4'b0000;
        repeat (5) @(posedge clk);
        bus(1'b1, 5'h08, 32'h1, rd);
        bus(1'b0, 5'h08, 32'd0, rd);
        chk("w1c_race_pending", rd, 32'h1);
        bus(1'b0, 5'h00, 32'd0, rd);
        chk("w1c_race_sw_state", rd, 32'h0);
        chk("w1c_race_irq", {31'd0, irq}, 32'd1);
        bus(1'b1, 5'h08, 32'hF, rd);
        bus(1'b0, 5'h08, 32'd0, rd);
        chk("clear_all_pending", rd, 32'h0);

        // LED write and single-cycle response
        bus(1'b1, 5'h04, 32'hA, rd);
`ifndef BOARD_IO_PWM_EN
        chk("led_pin_a", {28'd0, pin_led}, 32'hA);
`endif
        @(negedge clk);
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        bus(1'b0, 5'h04, 32'd0, rd);
        chk("led_read_a", rd, 32'hA);

        // Back-to-back requests: second waits out the response cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'h04;
        req_wdata = 32'h3;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        chk("b2b_ready_low", {31'd0, req_ready}, 32'd0);
        req_wdata = 32'h5;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_gap_resp", {31'd0, resp_valid}, 32'd0);
        chk("b2b_gap_ready", {31'd0, req_ready}, 32'd1);
`ifndef BOARD_IO_PWM_EN
        chk("b2b_led_first", {28'd0, pin_led}, 32'h3);
`endif
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        bus(1'b0, 5'h04, 32'd0, rd);
        chk("b2b_led_second", rd, 32'h5);

        // Unmapped offset
        bus(1'b0, 5'h1C, 32'd0, rd);
        chk("unmapped_read", rd, 32'h0);
        bus(1'b1, 5'h1C, 32'hFFFF_FFFF, rd);
        bus(1'b0, 5'h04, 32'd0, rd);
        chk("unmapped_led", rd, 32'h5);
        bus(1'b0, 5'h0C, 32'd0, rd);
        chk("unmapped_irq_en", rd, 32'h1);
        bus(1'b0, 5'h08, 32'd0, rd);
        chk("unmapped_pending", rd, 32'h0);

        // PWM / duty register
        bus(1'b1, 5'h04, 32'hF, rd);
`ifdef BOARD_IO_PWM_EN
        bus(1'b1, 5'h10, 32'd64, rd);
        bus(1'b0, 5'h10, 32'd0, rd);
        chk("pwm_duty_read", rd, 32'd64);
        begin
            int on_cnt;
            on_cnt = 0;
            repeat (4) @(negedge clk);
            repeat (256) begin
                @(negedge clk);
                if (pin_led == 4'hF) on_cnt++;
            end
            chk("pwm_on_64", on_cnt, 32'd64);
            bus(1'b1, 5'h10, 32'd0, rd);
            repeat (3) @(negedge clk);
            on_cnt = 0;
            repeat (256) begin
                @(negedge clk);
                if (pin_led != 4'h0) on_cnt++;
            end
            chk("pwm_duty0_off", on_cnt, 32'd0);
        end
`else
        bus(1'b0, 5'h10, 32'd0, rd);
        chk("nopwm_duty_read", rd, 32'h0);
        bus(1'b1, 5'h10, 32'h55, rd);
        bus(1'b0, 5'h10, 32'd0, rd);
        chk("nopwm_duty_ignored", rd, 32'h0);
        chk("nopwm_pin_led", {28'd0, pin_led}, 32'hF);
`endif

        // Reset asserted across the accept edge
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'h04;
        req_wdata = 32'hC;
        #2 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst_resp", {31'd0, resp_valid}, 32'd0);
        chk("midrst_led", {28'd0, pin_led}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_resp_after1", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("midrst_resp_after2", {31'd0, resp_valid}, 32'd0);
        bus(1'b0, 5'h04, 32'd0, rd);
        chk("midrst_led_read", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
